// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared types, defaults and sizing helper for the FIFO write arbiter
package fifo_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int N_DEFAULT         = 4;
    localparam int WIDTH_DEFAULT     = 16;
    localparam int MAX_BURST_DEFAULT = 8;

    // Bits needed to hold a beat count of 0..max_burst inclusive.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first request at or above ptr, modulo N
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] idx
);

    logic found;

    // Outer loop walks the search order, inner loop maps the offset to a constant bit index.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == ((int'(ptr) + k) % N))) begin
                    found     = 1'b1;
                    winner[i] = 1'b1;
                    idx       = PW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wrt_arbiter.sv
// rtl/fifo_wrt_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among N requesters
module fifo_wrt_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic               wrt_clk,
    input  logic               wrt_rst,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [N-1:0]       req_last,
    input  logic               full,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       ack,
    output logic               wrt_en,
    output logic [WIDTH-1:0]   wrt_data,
    output logic               busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = cnt_width(MAX_BURST);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [N-1:0]  pick_onehot;
    logic [PW-1:0] pick_idx;
    logic          gnt_req;
    logic          beat_last;
    logic          at_max;
    logic          rel;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_onehot),
        .idx    (pick_idx)
    );

    assign ack       = gnt & req & {N{~full}};
    assign wrt_en    = |ack;
    assign gnt_req   = |(gnt & req);
    assign beat_last = |(ack & req_last);
    assign cnt_inc   = cnt + CW'(1);
    assign at_max    = wrt_en && (cnt_inc == CW'(MAX_BURST));
    assign rel       = !gnt_req || beat_last || at_max;

    // gnt is one-hot or zero, so an OR of masked slices is a clean mux.
    always_comb begin
        wrt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                wrt_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge wrt_clk or posedge wrt_rst) begin
        if (wrt_rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (|req) begin
                        state   <= BURST;
                        gnt     <= pick_onehot;
                        gnt_idx <= pick_idx;
                        busy    <= 1'b1;
                    end else begin
                        gnt <= '0;
                    end
                end
                BURST: begin
                    if (wrt_en) begin
                        cnt <= cnt_inc;
                    end
                    if (rel) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wrt_arbiter.sv
// tb/tb_fifo_wrt_arbiter.sv - directed self-checking bench for fifo_wrt_arbiter
module tb_fifo_wrt_arbiter;

    localparam int N         = 4;
    localparam int WIDTH     = 16;
    localparam int MAX_BURST = 8;

    logic               wrt_clk;
    logic               wrt_rst;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_last;
    logic               full;
    logic [N-1:0]       gnt;
    logic [N-1:0]       ack;
    logic               wrt_en;
    logic [WIDTH-1:0]   wrt_data;
    logic               busy;

    int n_assert;
    int n_fail;
    int nacc;

    fifo_wrt_arbiter #(
        .N         (N),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wrt_clk  (wrt_clk),
        .wrt_rst  (wrt_rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .full     (full),
        .gnt      (gnt),
        .ack      (ack),
        .wrt_en   (wrt_en),
        .wrt_data (wrt_data),
        .busy     (busy)
    );

    initial begin
        wrt_clk = 1'b0;
        forever #5 wrt_clk = ~wrt_clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wrt_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        wrt_rst  = 1'b1;
        req      = '0;
        req_data = '0;
        req_last = '0;
        full     = 1'b0;
        tick();

        // reset state, with requests pending
        req      = 4'b1111;
        req_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        settle();
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_wrt_en", wrt_en, 0);
        check("rst_wrt_data", wrt_data, 0);
        tick();

        // single requester 0, 3-beat burst
        wrt_rst  = 1'b0;
        req      = 4'b0001;
        req_data = {16'h0, 16'h0, 16'h0, 16'hA001};
        settle();
        check("s1_idle_gnt", gnt, 0);
        check("s1_idle_wrt_en", wrt_en, 0);
        check("s1_idle_data", wrt_data, 0);
        tick();
        settle();
        check("s1_b1_gnt", gnt, 4'b0001);
        check("s1_b1_busy", busy, 1);
        check("s1_b1_wrt_en", wrt_en, 1);
        check("s1_b1_data", wrt_data, 16'hA001);
        tick();
        req_data[15:0] = 16'hA002;
        settle();
        check("s1_b2_wrt_en", wrt_en, 1);
        check("s1_b2_data", wrt_data, 16'hA002);
        tick();
        req_data[15:0] = 16'hA003;
        req_last       = 4'b0001;
        settle();
        check("s1_b3_wrt_en", wrt_en, 1);
        check("s1_b3_data", wrt_data, 16'hA003);
        tick();
        req      = '0;
        req_last = '0;
        settle();
        check("s1_done_busy", busy, 0);
        check("s1_done_gnt", gnt, 0);
        check("s1_done_wrt_en", wrt_en, 0);

        // all four requesting, no req_last: 0,1,2,3,0 with 8 beats each
        wrt_rst = 1'b1;
        tick();
        wrt_rst  = 1'b0;
        req      = 4'b1111;
        req_data = {16'hD000, 16'hC000, 16'hB000, 16'hA000};
        for (int g = 0; g < 5; g++) begin
            settle();
            check("s2_idle_gnt", gnt, 0);
            check("s2_idle_wrt_en", wrt_en, 0);
            tick();
            nacc = 0;
            for (int b = 0; b < MAX_BURST; b++) begin
                settle();
                check("s2_ack", ack, 4'b0001 << (g % 4));
                if (wrt_en) nacc++;
                tick();
            end
            check("s2_beats", nacc, MAX_BURST);
        end
        check("s2_last_data_seen_idle", wrt_data, 0);
        req = '0;

        // requester 2 (pointer at 1), full for 5 cycles with req_last in the last 3
        req      = 4'b0100;
        req_data = {16'h0, 16'h2001, 16'h0, 16'h0};
        settle();
        check("s3_idle_gnt", gnt, 0);
        tick();
        for (int b = 0; b < 2; b++) begin
            settle();
            check("s3_pre_ack", ack, 4'b0100);
            check("s3_pre_data", wrt_data, 16'h2001);
            tick();
        end
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_last = (k >= 2) ? 4'b0100 : 4'b0000;
            settle();
            check("s3_full_gnt", gnt, 4'b0100);
            check("s3_full_ack", ack, 0);
            check("s3_full_wrt_en", wrt_en, 0);
            check("s3_full_busy", busy, 1);
            tick();
        end
        full     = 1'b0;
        req_last = '0;
        for (int b = 0; b < MAX_BURST - 2; b++) begin
            settle();
            check("s3_post_gnt", gnt, 4'b0100);
            check("s3_post_ack", ack, 4'b0100);
            tick();
        end
        settle();
        check("s3_release_gnt", gnt, 0);
        req = '0;

        // requester 3: req_last while full is ignored, honoured on next accepted beat
        req      = 4'b1000;
        req_data = {16'h3003, 16'h0, 16'h0, 16'h0};
        settle();
        check("s4_idle_gnt", gnt, 0);
        tick();
        settle();
        check("s4_b1_ack", ack, 4'b1000);
        tick();
        full     = 1'b1;
        req_last = 4'b1000;
        settle();
        check("s4_full_ack", ack, 0);
        check("s4_full_gnt", gnt, 4'b1000);
        tick();
        full = 1'b0;
        settle();
        check("s4_hold_gnt", gnt, 4'b1000);
        check("s4_last_ack", ack, 4'b1000);
        check("s4_last_data", wrt_data, 16'h3003);
        tick();
        req      = '0;
        req_last = '0;
        settle();
        check("s4_release_gnt", gnt, 0);
        check("s4_release_busy", busy, 0);

        // requester 1 one-beat burst moves the pointer to 2
        req      = 4'b0010;
        req_last = 4'b0010;
        req_data = {16'h0, 16'h0, 16'h1111, 16'h0};
        settle();
        tick();
        settle();
        check("s5_gnt", gnt, 4'b0010);
        check("s5_ack", ack, 4'b0010);
        tick();
        req      = 4'b1000;
        req_last = '0;
        req_data = {16'h3333, 16'h0, 16'h0, 16'h0};
        settle();
        check("s5_idle_gnt", gnt, 0);
        tick();
        settle();
        check("s6_gnt", gnt, 4'b1000);
        for (int b = 0; b < 3; b++) begin
            settle();
            check("s6_ack", ack, 4'b1000);
            tick();
        end

        // reset on beat 4
        wrt_rst = 1'b1;
        settle();
        check("s6_rst_gnt", gnt, 0);
        check("s6_rst_ack", ack, 0);
        check("s6_rst_wrt_en", wrt_en, 0);
        check("s6_rst_data", wrt_data, 0);
        check("s6_rst_busy", busy, 0);
        tick();
        wrt_rst  = 1'b0;
        req      = 4'b0110;
        req_data = {16'h0, 16'h2222, 16'h1111, 16'h0};
        settle();
        check("s6_post_idle_wrt_en", wrt_en, 0);
        tick();
        settle();
        check("s6_restart_gnt", gnt, 4'b0010);

        // requester 1 drops mid-burst; requester 2 idle so 3 wins
        req = 4'b1011;
        settle();
        check("s7_b1_ack", ack, 4'b0010);
        check("s7_b1_data", wrt_data, 16'h1111);
        tick();
        req = 4'b1001;
        settle();
        check("s7_drop_ack", ack, 0);
        check("s7_drop_wrt_en", wrt_en, 0);
        check("s7_drop_gnt", gnt, 4'b0010);
        tick();
        settle();
        check("s7_release_gnt", gnt, 0);
        check("s7_release_busy", busy, 0);
        tick();
        settle();
        check("s7_next_gnt", gnt, 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
